// File: rtl/exec_muldiv_unit_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode helpers
// for the iterative multiply/divide execute unit.
package lib_muldiv;

    localparam logic [3:0] OPT_MUL   = 4'h8;
    localparam logic [3:0] OPT_MULHU = 4'h9;
    localparam logic [3:0] OPT_DIVU  = 4'hA;
    localparam logic [3:0] OPT_REMU  = 4'hB;
    localparam logic [3:0] OPT_DIV   = 4'hC;
    localparam logic [3:0] OPT_REM   = 4'hD;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic opt_legal(input logic [3:0] opt);
        return (opt >= OPT_MUL) && (opt <= OPT_REM);
    endfunction

    function automatic logic opt_is_mul(input logic [3:0] opt);
        return (opt == OPT_MUL) || (opt == OPT_MULHU);
    endfunction

    function automatic logic opt_is_div(input logic [3:0] opt);
        return opt_legal(opt) && !opt_is_mul(opt);
    endfunction

    function automatic logic opt_is_signed(input logic [3:0] opt);
        return (opt == OPT_DIV) || (opt == OPT_REM);
    endfunction

endpackage

// File: rtl/exec_muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on a {hi, lo} 2*XLEN accumulator.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic                is_div_i,
    input  logic [XLEN-1:0]     b_i,
    input  logic [2*XLEN-1:0]   acc_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          ge;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi the running sum.
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
        // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
        shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        ge      = shifted >= {1'b0, b_i};
        diff    = shifted - {1'b0, b_i};
        if (is_div_i) begin
            acc_o = {XLEN'(ge ? diff : shifted), acc_i[XLEN-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative multiply/divide execute unit with valid/ready request and
// response handshakes; retires BITS_PER_CYCLE bits per CALC cycle.
module exec_muldiv_unit
    import lib_muldiv::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_opt,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned N_ITER = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

    typedef struct packed {
        logic [3:0]        opt;
        logic [XLEN-1:0]   a_mag;
        logic [XLEN-1:0]   b_mag;
        logic              neg_q;
        logic              neg_r;
        logic [2*XLEN-1:0] acc;
        logic [CNT_W-1:0]  cnt;
    } op_t;

    state_e          state_q;
    op_t             op_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;

    logic            accept;
    logic            signed_op;
    logic            div_zero;
    logic [XLEN-1:0] a_mag_d;
    logic [XLEN-1:0] b_mag_d;
    logic [XLEN-1:0] dz_res;
    logic [XLEN-1:0] step_b;
    logic [XLEN-1:0] fix_res;

    logic [2*XLEN-1:0] chain [BITS_PER_CYCLE+1];

    assign req_ready  = (state_q == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

    always_comb begin
        signed_op = opt_is_signed(req_opt);
        a_mag_d   = (signed_op && req_a[XLEN-1]) ? -req_a : req_a;
        b_mag_d   = (signed_op && req_b[XLEN-1]) ? -req_b : req_b;
        div_zero  = opt_is_div(req_opt) && (req_b == '0);
        dz_res    = ((req_opt == OPT_DIVU) || (req_opt == OPT_DIV)) ? '1 : req_a;
    end

    assign step_b   = opt_is_mul(op_q.opt) ? op_q.a_mag : op_q.b_mag;
    assign chain[0] = op_q.acc;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(
            .XLEN(XLEN)
        ) u_step (
            .is_div_i (!opt_is_mul(op_q.opt)),
            .b_i      (step_b),
            .acc_i    (chain[g]),
            .acc_o    (chain[g+1])
        );
    end

    always_comb begin
        fix_res = '0;
        case (op_q.opt)
            OPT_MUL, OPT_DIVU:   fix_res = op_q.acc[XLEN-1:0];
            OPT_MULHU, OPT_REMU: fix_res = op_q.acc[2*XLEN-1:XLEN];
            OPT_DIV:  fix_res = op_q.neg_q ? -op_q.acc[XLEN-1:0] : op_q.acc[XLEN-1:0];
            OPT_REM:  fix_res = op_q.neg_r ? -op_q.acc[2*XLEN-1:XLEN] : op_q.acc[2*XLEN-1:XLEN];
            default:  fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else if (flush) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q.opt   <= req_opt;
                        op_q.a_mag <= a_mag_d;
                        op_q.b_mag <= b_mag_d;
                        op_q.neg_q <= signed_op && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                        op_q.neg_r <= signed_op && req_a[XLEN-1];
                        op_q.acc   <= opt_is_mul(req_opt) ? {{XLEN{1'b0}}, req_b}
                                                          : {{XLEN{1'b0}}, a_mag_d};
                        if (!opt_legal(req_opt)) begin
                            resp_data_q  <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end else if (div_zero) begin
                            resp_data_q  <= dz_res;
                            resp_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            op_q.cnt <= CNT_W'(N_ITER);
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    op_q.acc <= chain[BITS_PER_CYCLE];
                    op_q.cnt <= op_q.cnt - CNT_W'(1);
                    if (op_q.cnt == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    resp_data_q  <= fix_res;
                    resp_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
